dac_matrix_sequencer: RTL and testbench

Digital front end for the next-generation current-steering video DAC tile. It accepts pixel colour components one beat at a time over a shared narrow bus with a valid/ready handshake, and assembles them into a shadow set of `CHANNELS` codes. On a pixel commit strobe it transfers the set atomically to the active registers, which drive segmented DAC cells: thermometer-decoded MSBs plus binary LSBs. It sits between the pixel generator and the analog `csdac` macros, replacing direct wiring of one shared input byte to every channel.

---
 rtl/dac_matrix_pkg.sv | 22 ++
 rtl/dac_therm_decoder.sv | 43 ++++
 rtl/dac_matrix_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_dac_matrix_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_matrix_pkg
// Description : Shared types and helpers for the DAC matrix sequencer.
//               - state_t     : component-assembly state (FILL, FULL)
//               - therm_width : number of unary cells for a given MSB count
// Revision    : 1.0 - initial release
// ============================================================================
package dac_matrix_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,   // collecting component beats into the shadow set
        ST_FULL = 1'b1    // shadow set complete, waiting for commit
    } state_t;

    // A thermometer decoder for msb bits needs 2**msb-1 unary outputs.
    function automatic int therm_width(input int msb);
        return (2 ** msb) - 1;
    endfunction

endpackage : dac_matrix_pkg
`default_nettype wire

// File: rtl/dac_therm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : dac_therm_decoder
// Description : Combinational segmented-DAC decoder for one channel. The upper
//               MSB_BITS of the code (value m) drive unary cells [m-1:0]; the
//               remaining low bits pass straight through as binary enables.
//               blank forces every enable low.
// Ports       : code  [WIDTH]                 channel code
//               blank [1]                     force all enables to 0
//               therm [2**MSB_BITS-1]         unary cell enables
//               bin   [WIDTH-MSB_BITS]        binary LSB enables
// Revision    : 1.0 - initial release
// ============================================================================
module dac_therm_decoder
    import dac_matrix_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MSB_BITS = 4
) (
    input  logic [WIDTH-1:0]                 code,
    input  logic                             blank,
    output logic [therm_width(MSB_BITS)-1:0] therm,
    output logic [WIDTH-MSB_BITS-1:0]        bin
);

    localparam int c_TW = therm_width(MSB_BITS);

    logic [MSB_BITS-1:0] w_msb;
    assign w_msb = code[WIDTH-1 -: MSB_BITS];

    always_comb begin
        therm = '0;
        bin   = '0;
        if (!blank) begin
            for (int i = 0; i < c_TW; i++) begin
                therm[i] = (i < int'(w_msb));
            end
            bin = code[WIDTH-MSB_BITS-1:0];
        end
    end

endmodule : dac_therm_decoder
`default_nettype wire

// File: rtl/dac_matrix_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dac_matrix_sequencer
// Description : Assembles CHANNELS component codes, arriving one beat at a
//               time over a valid/ready bus, into a shadow set. A commit
//               strobe copies the set atomically into the active registers,
//               whose decoded (thermometer + binary) form drives the DAC
//               cells through an output register stage.
// Ports       : clk, rst         clock, synchronous active-high reset
//               in_valid/in_data component beat (channel 0 first)
//               in_ready         beat accepted this cycle (state FILL)
//               commit           pixel strobe
//               blank            force all DAC enables low
//               dac_therm        unary enables, channel c in slice c
//               dac_bin          binary enables, channel c in slice c
//               underrun         sticky: commit with incomplete set
//               err_count        saturating underrun counter
// Config      : DAC_MATRIX_ERRCNT_EN - when defined, err_count is an 8-bit
//               saturating counter; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_matrix_sequencer
    import dac_matrix_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int MSB_BITS = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic [WIDTH-1:0]                          in_data,
    output logic                                      in_ready,
    input  logic                                      commit,
    input  logic                                      blank,
    output logic [CHANNELS*therm_width(MSB_BITS)-1:0] dac_therm,
    output logic [CHANNELS*(WIDTH-MSB_BITS)-1:0]      dac_bin,
    output logic                                      underrun,
    output logic [7:0]                                err_count
);

    localparam int c_TW    = therm_width(MSB_BITS);
    localparam int c_BW    = WIDTH - MSB_BITS;
    localparam int c_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(CHANNELS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  w_idx_nxt;
    logic                w_accept;
    logic                w_load;
    logic                w_underrun_evt;

    logic [WIDTH-1:0]    r_shadow [CHANNELS];
    logic [WIDTH-1:0]    r_active [CHANNELS];
    logic                r_underrun;

    logic [CHANNELS*c_TW-1:0] w_therm;
    logic [CHANNELS*c_BW-1:0] w_bin;
    logic [CHANNELS*c_TW-1:0] r_therm;
    logic [CHANNELS*c_BW-1:0] r_bin;

    // in_ready depends only on the state register.
    assign in_ready = (r_state == ST_FILL);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_accept       = 1'b0;
        w_load         = 1'b0;
        w_underrun_evt = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_accept = in_valid;
                if (in_valid) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                if (commit) begin
                    if (in_valid && (r_idx == c_LAST_IDX)) begin
                        // Completing beat and commit coincide: the set
                        // commits directly and FULL is skipped.
                        w_load      = 1'b1;
                        w_state_nxt = ST_FILL;
                    end else begin
                        // Incomplete set: keep active codes, resync index.
                        w_underrun_evt = 1'b1;
                        w_idx_nxt      = '0;
                    end
                end
            end
            ST_FULL: begin
                if (commit) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow / active code storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_shadow[c] <= '0;
                r_active[c] <= '0;
            end
            r_underrun <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_accept && (r_idx == c_IDX_W'(c))) begin
                    r_shadow[c] <= in_data;
                end
                if (w_load) begin
                    // Bypass the beat being accepted alongside the commit.
                    r_active[c] <= (w_accept && (r_idx == c_IDX_W'(c))) ? in_data : r_shadow[c];
                end
            end
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign underrun = r_underrun;

    // ------------------------------------------------------------------
    // Per-channel decode and output register
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dac_therm_decoder #(
            .WIDTH    (WIDTH),
            .MSB_BITS (MSB_BITS)
        ) u_dec (
            .code  (r_active[c]),
            .blank (blank),
            .therm (w_therm[c*c_TW +: c_TW]),
            .bin   (w_bin[c*c_BW +: c_BW])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_therm <= '0;
            r_bin   <= '0;
        end else begin
            r_therm <= w_therm;
            r_bin   <= w_bin;
        end
    end

    assign dac_therm = r_therm;
    assign dac_bin   = r_bin;

    // ------------------------------------------------------------------
    // Underrun event counter
    // ------------------------------------------------------------------
`ifdef DAC_MATRIX_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'h00;
        end else if (w_underrun_evt && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'h00;
`endif

endmodule : dac_matrix_sequencer
`default_nettype wire

// File: tb/tb_dac_matrix_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_matrix_sequencer
// Description : Directed self-checking bench for dac_matrix_sequencer with
//               default parameters (3 channels, 8-bit codes, 4 MSBs).
//               Expected decoded values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_matrix_sequencer;

`ifdef DAC_MATRIX_ERRCNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        commit = 1'b0;
    logic        blank = 1'b0;
    logic [44:0] dac_therm;
    logic [11:0] dac_bin;
    logic        underrun;
    logic [7:0]  err_count;

    int vectors     = 0;
    int miscompares = 0;

    dac_matrix_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .commit    (commit),
        .blank     (blank),
        .dac_therm (dac_therm),
        .dac_bin   (dac_bin),
        .underrun  (underrun),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic with_commit);
        in_valid = 1'b1;
        in_data  = d;
        commit   = with_commit;
        step();
        in_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        commit = 1'b1;   // reset must win over a concurrent commit
        step();
        step();
        commit = 1'b0;
        rst    = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", in_ready); end
        vectors++;
        if (dac_therm !== 45'h0 || dac_bin !== 12'h0) begin
            miscompares++; $display("FAIL reset_outputs got therm %h bin %h want 0/0", dac_therm, dac_bin);
        end
        vectors++;
        if (underrun !== 1'b0 || err_count !== 8'h00) begin
            miscompares++; $display("FAIL reset_err got underrun %b cnt %0d want 0/0", underrun, err_count);
        end
    endtask

    task automatic test_basic();
        beat(8'hFF, 1'b0);
        beat(8'h80, 1'b0);
        beat(8'h0F, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_full_ready got %b want 0", in_ready); end
        commit = 1'b1;
        step();
        commit = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_after_commit got %b want 1", in_ready); end
        vectors++;
        if (dac_therm !== 45'h0 || dac_bin !== 12'h0) begin
            miscompares++; $display("FAIL basic_latency got therm %h bin %h want 0/0", dac_therm, dac_bin);
        end
        step();
        vectors++;
        if (dac_therm !== {15'h0000, 15'h00FF, 15'h7FFF} || dac_bin !== {4'hF, 4'h0, 4'hF}) begin
            miscompares++; $display("FAIL basic_decode got therm %h bin %h want %h %h",
                dac_therm, dac_bin, {15'h0000, 15'h00FF, 15'h7FFF}, {4'hF, 4'h0, 4'hF});
        end
    endtask

    task automatic test_commit_overlap();
        beat(8'hC0, 1'b0);
        beat(8'h05, 1'b0);
        beat(8'h9E, 1'b1);
        vectors++;
        if (in_ready !== 1'b1 || underrun !== 1'b0) begin
            miscompares++; $display("FAIL overlap_ready got ready %b underrun %b want 1/0", in_ready, underrun);
        end
        // Next pixel back to back; first beat of it shows the previous commit.
        beat(8'h11, 1'b0);
        vectors++;
        if (dac_therm !== {15'h01FF, 15'h0000, 15'h0FFF} || dac_bin !== {4'hE, 4'h5, 4'h0}) begin
            miscompares++; $display("FAIL overlap_decode got therm %h bin %h want %h %h",
                dac_therm, dac_bin, {15'h01FF, 15'h0000, 15'h0FFF}, {4'hE, 4'h5, 4'h0});
        end
        beat(8'h22, 1'b0);
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", in_ready); end
        beat(8'h33, 1'b1);
        step();
        vectors++;
        if (dac_therm !== {15'h0007, 15'h0003, 15'h0001} || dac_bin !== {4'h3, 4'h2, 4'h1} || underrun !== 1'b0) begin
            miscompares++; $display("FAIL b2b_decode got therm %h bin %h underrun %b want %h %h 0",
                dac_therm, dac_bin, underrun, {15'h0007, 15'h0003, 15'h0001}, {4'h3, 4'h2, 4'h1});
        end
    endtask

    task automatic test_full_hold();
        beat(8'h12, 1'b0);
        beat(8'h34, 1'b0);
        beat(8'h56, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_hold_ready cycle %0d got %b want 0", i, in_ready); end
            step();
        end
        in_valid = 1'b0;
        commit   = 1'b1;
        step();
        commit   = 1'b0;
        step();
        vectors++;
        if (dac_therm !== {15'h001F, 15'h0007, 15'h0001} || dac_bin !== {4'h6, 4'h4, 4'h2}) begin
            miscompares++; $display("FAIL full_hold_shadow got therm %h bin %h want %h %h",
                dac_therm, dac_bin, {15'h001F, 15'h0007, 15'h0001}, {4'h6, 4'h4, 4'h2});
        end
    endtask

    task automatic test_blank();
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'hFF, 1'b1);
        step();
        vectors++;
        if (dac_therm !== {3{15'h7FFF}} || dac_bin !== 12'hFFF) begin
            miscompares++; $display("FAIL blank_pre got therm %h bin %h want all ones", dac_therm, dac_bin);
        end
        blank = 1'b1;
        step();
        vectors++;
        if (dac_therm !== 45'h0 || dac_bin !== 12'h0) begin
            miscompares++; $display("FAIL blank_on got therm %h bin %h want 0/0", dac_therm, dac_bin);
        end
        step();
        vectors++;
        if (dac_therm !== 45'h0 || dac_bin !== 12'h0) begin
            miscompares++; $display("FAIL blank_hold got therm %h bin %h want 0/0", dac_therm, dac_bin);
        end
        blank = 1'b0;
        step();
        vectors++;
        if (dac_therm !== {3{15'h7FFF}} || dac_bin !== 12'hFFF) begin
            miscompares++; $display("FAIL blank_off got therm %h bin %h want all ones", dac_therm, dac_bin);
        end
    endtask

    task automatic test_underrun();
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        vectors++;
        if (dac_therm !== {3{15'h7FFF}} || dac_bin !== 12'hFFF) begin
            miscompares++; $display("FAIL underrun_hold got therm %h bin %h want all ones", dac_therm, dac_bin);
        end
        vectors++;
        if (underrun !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL underrun_flag got underrun %b ready %b want 1/1", underrun, in_ready);
        end
        vectors++;
        if (err_count !== (c_CNT_EN ? 8'd1 : 8'd0)) begin
            miscompares++; $display("FAIL underrun_count got %0d want %0d", err_count, c_CNT_EN ? 1 : 0);
        end
        beat(8'h31, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'h47, 1'b1);
        step();
        vectors++;
        if (dac_therm !== {15'h000F, 15'h03FF, 15'h0007} || dac_bin !== {4'h7, 4'h2, 4'h1}) begin
            miscompares++; $display("FAIL underrun_resync got therm %h bin %h want %h %h",
                dac_therm, dac_bin, {15'h000F, 15'h03FF, 15'h0007}, {4'h7, 4'h2, 4'h1});
        end
        vectors++;
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky got %b want 1", underrun); end
    endtask

    task automatic test_errcnt_saturate();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL errcnt_rst_clear got %b want 0", underrun); end
        commit = 1'b1;
        for (int i = 0; i < 300; i++) step();
        commit = 1'b0;
        step();
        vectors++;
        if (err_count !== (c_CNT_EN ? 8'd255 : 8'd0) || underrun !== 1'b1) begin
            miscompares++; $display("FAIL errcnt_saturate got cnt %0d underrun %b want %0d 1",
                err_count, underrun, c_CNT_EN ? 255 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_commit_overlap();
        test_full_hold();
        test_blank();
        test_underrun();
        test_errcnt_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dac_matrix_sequencer
`default_nettype wire
